// File: rtl/xor_descrambler_32.sv
// rtl/xor_descrambler_32.sv - additive LFSR descrambler, one word per cycle, 1-cycle latency
// Optional out_parity port enabled by macro XOR_DESCR_PARITY_EN.
module xor_descrambler_32 #(
  parameter int               WIDTH = 32,
  parameter logic [0:WIDTH-1] POLY  = 32'h04C11DB7,
  parameter logic [0:WIDTH-1] SEED  = 32'h00000001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [0:WIDTH-1] seed_value,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] out_data,
`ifdef XOR_DESCR_PARITY_EN
  output logic             out_parity,
`endif
  output logic [15:0]      word_count,
  output logic             locked
);

  typedef enum logic {
    S_UNSYNC = 1'b0,
    S_RUN    = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [0:WIDTH-1] r_lfsr;
  logic [0:WIDTH-1] w_lfsr_step;
  logic [0:WIDTH-1] w_plain;
  logic [0:WIDTH-1] r_out_data;
  logic             r_out_valid;
  logic [15:0]      r_word_count;
  logic             w_accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_UNSYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // RUN is absorbing; only reset leaves it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_UNSYNC: if (seed_load) w_state_next = S_RUN;
      S_RUN:    w_state_next = S_RUN;
      default:  w_state_next = S_UNSYNC;
    endcase
  end

  assign in_ready    = (r_state == S_RUN) && !seed_load && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_plain     = in_data ^ r_lfsr;
  // Galois step: index 0 is the MSB, so shifting toward index 0 is a left shift.
  assign w_lfsr_step = {r_lfsr[1:WIDTH-1], 1'b0} ^ (r_lfsr[0] ? POLY : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr       <= SEED;
      r_word_count <= 16'd0;
    end else if (seed_load) begin
      r_lfsr       <= (seed_value == '0) ? SEED : seed_value;
      r_word_count <= 16'd0;
    end else if (w_accept) begin
      r_lfsr       <= w_lfsr_step;
      r_word_count <= r_word_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_plain;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef XOR_DESCR_PARITY_EN
  logic r_out_parity;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_parity <= 1'b0;
    end else if (w_accept) begin
      r_out_parity <= ^w_plain;
    end
  end

  assign out_parity = r_out_parity;
`endif

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign word_count = r_word_count;
  assign locked     = (r_state == S_RUN);

endmodule

// File: doc/xor_descrambler_32.md
Name: xor_descrambler_32

Overview:
- Receive-side counterpart of the ALU XOR datapath: an additive descrambler that recovers plain data words by XOR with a locally generated LFSR keystream.
- The matching scrambler XORs data with an identical keystream. This block is the other end of that link: the decoder, sitting between a scrambled word stream and the consumer.
- Fully pipelined, one word per cycle, valid/ready handshakes on both sides, 1-cycle latency through a single output register.

Parameters:
- WIDTH, 32, data/keystream width in bits; vectors are declared [0:WIDTH-1] with bit 0 as MSB.
- POLY, 32'h04C11DB7, Galois feedback mask applied when the LFSR MSB is 1.
- SEED, 32'h00000001, substitute seed loaded whenever seed_value == 0.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- seed_load  in  1  load seed_value into the LFSR; enter/stay in RUN.
- seed_value  in  WIDTH  keystream seed.
- in_valid  in  1  scrambled word present.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  WIDTH  scrambled word.
- out_valid  out  1  descrambled word present.
- out_ready  in  1  consumer takes the word this cycle.
- out_data  out  WIDTH  descrambled word.
- word_count  out  16  number of words accepted since the last reset or seed_load; wraps 0xFFFF -> 0x0000.
- locked  out  1  high in state RUN.

Behaviour:
- Reset, sampled on the clk rising edge: state=UNSYNC, LFSR=SEED, out_valid=0, out_data=0, word_count=0, locked=0. Reset overrides every other input.
- FSM:
  - UNSYNC: in_ready=0. seed_load -> RUN.
  - RUN: remains in RUN until reset. No other exit.
- in_ready = (state==RUN) && !seed_load && (!out_valid || out_ready). This is combinational.
- Accept: in_valid && in_ready at an edge produces:
  - out_data <= in_data ^ LFSR;
  - out_valid <= 1;
  - LFSR <= ((LFSR<<1) & mask) ^ (LFSR MSB ? POLY : 0), where mask is WIDTH bits;
  - word_count += 1.
- Output hold: if out_valid && !out_ready, out_data is held stable and no input is accepted.
- Output drain: if out_valid && out_ready and there is no accept that cycle, out_valid <= 0 and out_data keeps its last value.
- Simultaneous drain and accept: out_valid stays 1 and the new word replaces the old. Full throughput is one word per cycle.
- seed_load, in any state:
  - LFSR <= (seed_value==0) ? SEED : seed_value;
  - word_count <= 0;
  - no input is accepted that cycle;
  - a pending output word is preserved and drains normally.
- LFSR never holds 0: a zero seed is replaced by SEED, and a Galois step from a nonzero state is always nonzero.
- locked = (state==RUN), registered.
- Reset mid-stream: a pending output word is discarded (out_valid=0) and the block returns to UNSYNC.

Optional Feature:
- Macro XOR_DESCR_PARITY_EN.
- When defined:
  - adds output port out_parity (1 bit), registered alongside out_data;
  - out_parity = XOR-reduction of the descrambled word;
  - reset value 0;
  - held and updated under exactly the same rules as out_data.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then in_valid=1 with no seed_load -> in_ready=0, out_valid=0, locked=0 for 10 cycles.
2. seed_load with seed_value=0x00000001, then words 0xFFFFFFFF and 0x00000000 back to back with out_ready=1 -> out_data 0xFFFFFFFE then 0x00000002 on consecutive cycles, each 1 cycle after accept; word_count=2.
3. seed_value=0x80000000, send words 0x0 and 0x0 -> out_data 0x80000000 then 0x04C11DB7.
4. seed_value=0x00000000, send word 0x0 -> out_data 0x00000001 (SEED substituted).
5. out_ready=0 while out_valid=1 for 3 cycles with in_valid=1 -> in_ready=0, out_data stable, LFSR and word_count unchanged. Then set out_ready=1 -> drain and accept in the same cycle, out_valid stays 1.
6. Assert reset while out_valid=1 and word_count=5 -> next cycle out_valid=0, word_count=0, locked=0. With XOR_DESCR_PARITY_EN defined, in the scenario 2 stream out_parity is 1 then 1 (31 ones, then one 1).
